// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the core + memory side.
interface rv32i_mem_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_wstrb;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
   logic        owner_d;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner_d
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner_d
   );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between
// instruction fetch and load/store; all outputs are registered.
module rv32i_mem_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   rv32i_mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e     state_q;
   logic       last_owner_q;
   logic       we_q;
   logic [3:0] cnt_q;
   logic       grant_data;

   // Data wins when it is the only requester, or on a tie when fetch owned the last access.
   always_comb begin
      grant_data = bus.d_req & (~bus.i_req | ~last_owner_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         last_owner_q  <= 1'b0;
         we_q          <= 1'b0;
         cnt_q         <= 4'd0;
         bus.i_ack     <= 1'b0;
         bus.i_rdata   <= 32'd0;
         bus.d_ack     <= 1'b0;
         bus.d_rdata   <= 32'd0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 4'd0;
         bus.mem_addr  <= 32'd0;
         bus.mem_wdata <= 32'd0;
         bus.busy      <= 1'b0;
         bus.owner_d   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.i_req || bus.d_req) begin
                  state_q     <= StAccess;
                  bus.busy    <= 1'b1;
                  bus.mem_en  <= 1'b1;
                  bus.owner_d <= grant_data;
                  cnt_q       <= 4'(WAIT_CYCLES);
                  if (grant_data) begin
                     we_q          <= bus.d_we;
                     bus.mem_addr  <= bus.d_addr & ~32'h3;
                     bus.mem_we    <= bus.d_we ? bus.d_wstrb : 4'd0;
                     bus.mem_wdata <= bus.d_wdata;
                  end else begin
                     we_q          <= 1'b0;
                     bus.mem_addr  <= bus.i_addr & ~32'h3;
                     bus.mem_we    <= 4'd0;
                     bus.mem_wdata <= 32'd0;
                  end
               end
            end
            StAccess: begin
               bus.mem_en <= 1'b0;
               if (cnt_q == 4'd0) begin
                  state_q <= StDone;
                  if (bus.owner_d) begin
                     bus.d_ack <= 1'b1;
                     if (!we_q) bus.d_rdata <= bus.mem_rdata;
                  end else begin
                     bus.i_ack   <= 1'b1;
                     bus.i_rdata <= bus.mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StDone: begin
               bus.i_ack    <= 1'b0;
               bus.d_ack    <= 1'b0;
               bus.busy     <= 1'b0;
               last_owner_q <= bus.owner_d;
               state_q      <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: a WAIT_CYCLES=2 instance driven from a per-cycle
// vector table plus hand sequences, and a WAIT_CYCLES=1 instance for back-to-back fetches.
module tb_rv32i_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   rv32i_mem_arbiter_if bus2 ();
   rv32i_mem_arbiter_if bus1 ();

   rv32i_mem_arbiter #(.WAIT_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   rv32i_mem_arbiter #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory models: read data is valid only in the cycle WAIT_CYCLES after mem_en.
   logic [3:0]  age2, age1;
   logic [31:0] lat2, lat1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age2 <= 4'd0; lat2 <= 32'd0; age1 <= 4'd0; lat1 <= 32'd0;
      end else begin
         if (bus2.mem_en) begin age2 <= 4'd1; lat2 <= bus2.mem_addr; end
         else if (age2 != 4'd0 && age2 != 4'd15) age2 <= age2 + 4'd1;
         if (bus1.mem_en) begin age1 <= 4'd1; lat1 <= bus1.mem_addr; end
         else if (age1 != 4'd0 && age1 != 4'd15) age1 <= age1 + 4'd1;
      end
   end
   assign bus2.mem_rdata = (age2 == 4'd2) ? mem_word(lat2) : 32'hBAD0_BAD0;
   assign bus1.mem_rdata = (age1 == 4'd1) ? mem_word(lat1) : 32'hBAD0_BAD0;

   typedef struct {
      logic        i_req;
      logic        d_req;
      logic [31:0] i_addr;
      logic        e_i_ack;
      logic        e_d_ack;
      logic        e_mem_en;
      logic        e_busy;
      logic        e_owner;
      logic [31:0] e_mem_addr;
      logic [31:0] e_i_rdata;
      logic [31:0] e_d_rdata;
   } vec_t;

   function automatic vec_t mk(input int ir, input int dr, input logic [31:0] ia,
                               input int eia, input int eda, input int een, input int eb,
                               input int eo, input logic [31:0] ema, input logic [31:0] eir,
                               input logic [31:0] edr);
      vec_t t;
      t.i_req = ir[0];     t.d_req = dr[0];    t.i_addr = ia;
      t.e_i_ack = eia[0];  t.e_d_ack = eda[0]; t.e_mem_en = een[0];
      t.e_busy = eb[0];    t.e_owner = eo[0];  t.e_mem_addr = ema;
      t.e_i_rdata = eir;   t.e_d_rdata = edr;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   localparam logic [31:0] DB = 32'hDEAD_BEEF;
   localparam logic [31:0] DV = 32'h0040_FFBF;
   localparam logic [31:0] IV = 32'h2008_DFF7;

   vec_t        tbl [22];
   logic [31:0] w1_exp [3];
   int          en_cnt;

   initial begin
      bus2.i_req = 0; bus2.i_addr = 0; bus2.d_req = 0; bus2.d_we = 0;
      bus2.d_wstrb = 0; bus2.d_addr = 32'h40; bus2.d_wdata = 0;
      bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
      bus1.d_wstrb = 0; bus1.d_addr = 0; bus1.d_wdata = 0;

      // Single fetch, then a sustained tie: data, fetch, data.
      tbl[0]  = mk(1, 0, 32'h1006, 0, 0, 0, 0, 0, 32'h0,    0,  0);
      tbl[1]  = mk(1, 0, 32'h1006, 0, 0, 1, 1, 0, 32'h1004, 0,  0);
      tbl[2]  = mk(1, 0, 32'h1006, 0, 0, 0, 1, 0, 32'h0,    0,  0);
      tbl[3]  = mk(1, 0, 32'h1006, 0, 0, 0, 1, 0, 32'h0,    0,  0);
      tbl[4]  = mk(0, 0, 32'h1006, 1, 0, 0, 1, 0, 32'h0,    DB, 0);
      tbl[5]  = mk(0, 0, 32'h2008, 0, 0, 0, 0, 0, 32'h0,    DB, 0);
      tbl[6]  = mk(1, 1, 32'h2008, 0, 0, 0, 0, 0, 32'h0,    DB, 0);
      tbl[7]  = mk(1, 1, 32'h2008, 0, 0, 1, 1, 1, 32'h40,   DB, 0);
      tbl[8]  = mk(1, 1, 32'h2008, 0, 0, 0, 1, 1, 32'h0,    DB, 0);
      tbl[9]  = mk(1, 1, 32'h2008, 0, 0, 0, 1, 1, 32'h0,    DB, 0);
      tbl[10] = mk(1, 1, 32'h2008, 0, 1, 0, 1, 1, 32'h0,    DB, DV);
      tbl[11] = mk(1, 1, 32'h2008, 0, 0, 0, 0, 1, 32'h0,    DB, DV);
      tbl[12] = mk(1, 1, 32'h2008, 0, 0, 1, 1, 0, 32'h2008, DB, DV);
      tbl[13] = mk(1, 1, 32'h2008, 0, 0, 0, 1, 0, 32'h0,    DB, DV);
      tbl[14] = mk(1, 1, 32'h2008, 0, 0, 0, 1, 0, 32'h0,    DB, DV);
      tbl[15] = mk(1, 1, 32'h2008, 1, 0, 0, 1, 0, 32'h0,    IV, DV);
      tbl[16] = mk(1, 1, 32'h2008, 0, 0, 0, 0, 0, 32'h0,    IV, DV);
      tbl[17] = mk(1, 1, 32'h2008, 0, 0, 1, 1, 1, 32'h40,   IV, DV);
      tbl[18] = mk(1, 1, 32'h2008, 0, 0, 0, 1, 1, 32'h0,    IV, DV);
      tbl[19] = mk(1, 1, 32'h2008, 0, 0, 0, 1, 1, 32'h0,    IV, DV);
      tbl[20] = mk(0, 0, 32'h2008, 0, 1, 0, 1, 1, 32'h0,    IV, DV);
      tbl[21] = mk(0, 0, 32'h2008, 0, 0, 0, 0, 1, 32'h0,    IV, DV);
      w1_exp[0] = 32'h0800_F7FF; w1_exp[1] = 32'h0804_F7FB; w1_exp[2] = 32'h0808_F7F7;

      // Reset state of both instances
      @(negedge clk);
      chk("rst_ctl2", 32'({bus2.i_ack, bus2.d_ack, bus2.busy, bus2.owner_d, bus2.mem_en,
                           bus2.mem_we}), 32'd0);
      chk("rst_data2", bus2.i_rdata | bus2.d_rdata | bus2.mem_addr | bus2.mem_wdata, 32'd0);
      chk("rst_ctl1", 32'({bus1.i_ack, bus1.busy, bus1.mem_en, bus1.owner_d}), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;

      for (int k = 0; k < 22; k++) begin
         bus2.i_req = tbl[k].i_req;
         bus2.d_req = tbl[k].d_req;
         bus2.i_addr = tbl[k].i_addr;
         @(negedge clk);
         chk("i_ack", 32'(bus2.i_ack), 32'(tbl[k].e_i_ack));
         chk("d_ack", 32'(bus2.d_ack), 32'(tbl[k].e_d_ack));
         chk("mem_en", 32'(bus2.mem_en), 32'(tbl[k].e_mem_en));
         chk("busy", 32'(bus2.busy), 32'(tbl[k].e_busy));
         chk("owner_d", 32'(bus2.owner_d), 32'(tbl[k].e_owner));
         chk("i_rdata", bus2.i_rdata, tbl[k].e_i_rdata);
         chk("d_rdata", bus2.d_rdata, tbl[k].e_d_rdata);
         if (tbl[k].e_mem_en) begin
            chk("mem_addr", bus2.mem_addr, tbl[k].e_mem_addr);
            chk("mem_we_load", 32'(bus2.mem_we), 32'd0);
         end
         next_cycle();
      end

      // Store: operands change after the grant edge; d_rdata must be untouched.
      bus2.d_req = 1; bus2.d_we = 1; bus2.d_wstrb = 4'b0011;
      bus2.d_addr = 32'h20; bus2.d_wdata = 32'h1234_5678;
      en_cnt = 0;
      for (int s = 0; s < 6; s++) begin
         if (s == 1) begin bus2.d_addr = 32'h99; bus2.d_wdata = 32'h0; end
         if (s == 4) bus2.d_req = 0;
         @(negedge clk);
         if (bus2.mem_en) en_cnt++;
         if (s >= 1 && s <= 3) begin
            chk("st_mem_we", 32'(bus2.mem_we), 32'h3);
            chk("st_mem_wdata", bus2.mem_wdata, 32'h1234_5678);
            chk("st_mem_addr", bus2.mem_addr, 32'h20);
         end
         chk("st_d_ack", 32'(bus2.d_ack), 32'(s == 4));
         next_cycle();
      end
      chk("st_en_count", 32'(en_cnt), 32'd1);
      chk("st_d_rdata", bus2.d_rdata, DV);
      bus2.d_we = 0; bus2.d_wstrb = 0; bus2.d_addr = 32'h40;

      // Fetch request withdrawn mid-ACCESS still completes.
      bus2.i_req = 1; bus2.i_addr = 32'h300;
      for (int w = 0; w < 6; w++) begin
         if (w == 2) bus2.i_req = 0;
         @(negedge clk);
         chk("wd_i_ack", 32'(bus2.i_ack), 32'(w == 4));
         chk("wd_d_ack", 32'(bus2.d_ack), 32'd0);
         if (w == 4) chk("wd_i_rdata", bus2.i_rdata, 32'h0300_FCFF);
         next_cycle();
      end

      // Reset mid-ACCESS: outputs clear at once, no ack, then a tie grants data.
      bus2.i_req = 1; bus2.i_addr = 32'h400;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      chk("rm_mem_en", 32'(bus2.mem_en), 32'd1);
      next_cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("rm_ctl", 32'({bus2.i_ack, bus2.d_ack, bus2.busy, bus2.owner_d, bus2.mem_en,
                         bus2.mem_we}), 32'd0);
      chk("rm_i_rdata", bus2.i_rdata, 32'd0);
      chk("rm_d_rdata", bus2.d_rdata, 32'd0);
      chk("rm_mem_bus", bus2.mem_addr | bus2.mem_wdata, 32'd0);
      bus2.i_req = 0;
      #3 rst_n = 1'b1;
      next_cycle();
      bus2.i_req = 1; bus2.d_req = 1;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) begin bus2.i_req = 0; bus2.d_req = 0; end
         @(negedge clk);
         chk("rm_i_ack", 32'(bus2.i_ack), 32'd0);
         chk("rm_d_ack", 32'(bus2.d_ack), 32'(k == 4));
         if (k == 1) chk("rm_owner", 32'(bus2.owner_d), 32'd1);
         if (k == 4) chk("rm_d_rdata2", bus2.d_rdata, DV);
         next_cycle();
      end

      // WAIT_CYCLES=1: continuous fetches ack every 4 cycles.
      for (int f = 0; f < 13; f++) begin
         bus1.i_req = (f < 11);
         bus1.i_addr = 32'h800 + 32'(4 * (f / 4));
         @(negedge clk);
         chk("w1_i_ack", 32'(bus1.i_ack), 32'(f % 4 == 3));
         chk("w1_mem_en", 32'(bus1.mem_en), 32'(f % 4 == 1 && f < 12));
         if (f % 4 == 3) chk("w1_i_rdata", bus1.i_rdata, w1_exp[f / 4]);
         next_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
